// File: rtl/jk_pkg.sv
// Shared types and constants for JK-stage based sequencers.
package jk_pkg;

    // Counter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } jk_cnt_state_t;

    // Per-bit JK excitation codes, packed as {J, K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation encoder: derives J/K per bit so a JK bank
// holding i_q moves to i_n on the next edge. Never emits the toggle code.
module jk_excite #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k
);

    // Set bits that rise, reset bits that fall, hold the rest
    always_comb begin
        o_j = ~i_q & i_n;
        o_k = i_q & ~i_n;
    end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Programmable modulo-N up/down counter built on a JK stage bank, with a
// run/pause/one-shot sequencer and exported J/K excitation.
module jk_counter_ctrl
    import jk_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    generate
        if (MODULO < 2 || MODULO > (1 << WIDTH)) begin : g_bad_modulo
            $error("jk_counter_ctrl: MODULO must lie in 2..2**WIDTH");
        end
    endgenerate

    // One extra bit so MODULO == 2**WIDTH compares correctly
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);

    jk_cnt_state_t    r_state;
    jk_cnt_state_t    w_state_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_n;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_cnt;
    logic [WIDTH-1:0] w_load_sat;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_q_oor;
    logic             w_up_wrap;
    logic             w_dn_wrap;
    logic             w_wrap;
    logic             w_tc;

    // Next count candidates: wrapped up/down step and saturated load value.
    // An out-of-range q is treated as terminal in both directions.
    always_comb begin
        w_q_oor    = ({1'b0, r_q} >= MOD_EXT);
        w_up_wrap  = w_q_oor || (r_q == MAX_CNT);
        w_dn_wrap  = w_q_oor || (r_q == '0);
        w_wrap     = dir ? w_up_wrap : w_dn_wrap;
        if (dir) begin
            w_cnt = w_up_wrap ? '0 : r_q + WIDTH'(1);
        end else begin
            w_cnt = w_dn_wrap ? MAX_CNT : r_q - WIDTH'(1);
        end
        w_load_sat = ({1'b0, load_val} >= MOD_EXT) ? MAX_CNT : load_val;
    end

    // Sequencer next state, next count and terminal count; load > stop > start > count
    always_comb begin
        w_state_next = r_state;
        w_n          = r_q;
        w_tc         = 1'b0;
        if (reset) begin
            if (load) begin
                w_n = w_load_sat;
                if (r_state == DONE) begin
                    w_state_next = IDLE;
                end
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (start && !stop) begin
                            w_state_next = COUNT;
                        end
                    end
                    COUNT: begin
                        if (stop) begin
                            w_state_next = PAUSE;
                        end else begin
                            w_n  = w_cnt;
                            w_tc = dir ? (r_q == MAX_CNT) : (r_q == '0);
                            if (oneshot && w_wrap) begin
                                w_state_next = DONE;
                            end
                        end
                    end
                    PAUSE: begin
                        if (stop) begin
                            w_state_next = IDLE;
                        end else if (start) begin
                            w_state_next = COUNT;
                        end
                    end
                    DONE: begin
                        if (start && !stop) begin
                            w_state_next = COUNT;
                        end
                    end
                    default: w_state_next = IDLE;
                endcase
            end
        end
    end

    jk_excite #(
        .WIDTH (WIDTH)
    ) u_excite (
        .i_q (r_q),
        .i_n (w_n),
        .o_j (w_j),
        .o_k (w_k)
    );

    // JK stage behaviour per bit: set on J, clear on K, else hold
    always_comb begin
        w_q_next = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_j[i]) begin
                w_q_next[i] = 1'b1;
            end else if (w_k[i]) begin
                w_q_next[i] = 1'b0;
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // JK stage bank holding the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q     = r_q;
    assign j_vec = w_j;
    assign k_vec = w_k;
    assign tc    = w_tc;
    assign busy  = (r_state == COUNT) || (r_state == PAUSE);
    assign done  = (r_state == DONE);

    a_jk_matches_next : assert property (@(posedge clk) disable iff (!reset)
        w_q_next == w_n);

    a_no_toggle_code : assert property (@(posedge clk) disable iff (!reset)
        (w_j & w_k) == '0);

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Testbench for jk_counter_ctrl: directed sequences plus random stimulus,
// checked against a behavioural model through an expected-result queue.
module tb_jk_counter_ctrl;

    localparam int WIDTH  = 4;
    localparam int MODULO = 10;

    localparam int M_IDLE  = 0;
    localparam int M_COUNT = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             oneshot;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             tc;
    logic             busy;
    logic             done;

    int               n_chk  = 0;
    int               n_fail = 0;
    exp_t             sb_q[$];
    int               m_state;
    logic [WIDTH-1:0] m_q;

    jk_counter_ctrl #(
        .WIDTH  (WIDTH),
        .MODULO (MODULO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .oneshot  (oneshot),
        .q        (q),
        .j_vec    (j_vec),
        .k_vec    (k_vec),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model of one clock edge
    task automatic model(input logic st, input logic sp, input logic d, input logic l,
                         input logic [WIDTH-1:0] lv, input logic os,
                         output logic [WIDTH-1:0] n, output int ns, output logic t);
        int qi;
        qi = int'(m_q);
        n  = m_q;
        ns = m_state;
        t  = 1'b0;
        if (l) begin
            n = (int'(lv) >= MODULO) ? WIDTH'(MODULO - 1) : lv;
            if (m_state == M_DONE) ns = M_IDLE;
        end else if (m_state == M_IDLE) begin
            if (st && !sp) ns = M_COUNT;
        end else if (m_state == M_COUNT) begin
            if (sp) begin
                ns = M_PAUSE;
            end else begin
                if (d) begin
                    t = (qi == MODULO - 1);
                    n = t ? '0 : WIDTH'(qi + 1);
                end else begin
                    t = (qi == 0);
                    n = t ? WIDTH'(MODULO - 1) : WIDTH'(qi - 1);
                end
                if (os && t) ns = M_DONE;
            end
        end else if (m_state == M_PAUSE) begin
            if (sp) ns = M_IDLE;
            else if (st) ns = M_COUNT;
        end else begin
            if (st && !sp) ns = M_COUNT;
        end
    endtask

    // Drive one cycle of inputs, check combinational outputs, queue and check results
    task automatic cycle(input logic st, input logic sp, input logic d, input logic l,
                         input logic [WIDTH-1:0] lv, input logic os);
        logic [WIDTH-1:0] n;
        int               ns;
        logic             t;
        logic [WIDTH-1:0] pq, pj, pk;
        exp_t             e;
        @(negedge clk);
        start = st; stop = sp; dir = d; load = l; load_val = lv; oneshot = os;
        #1;
        model(st, sp, d, l, lv, os, n, ns, t);
        chk("tc", tc, t);
        chk("j_vec", j_vec, ~m_q & n);
        chk("k_vec", k_vec, m_q & ~n);
        sb_q.push_back('{q: n, busy: (ns == M_COUNT || ns == M_PAUSE), done: (ns == M_DONE)});
        pq = q; pj = j_vec; pk = k_vec;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk("q", q, e.q);
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
        end
        chk("jk_apply", q, (pq & ~pk) | pj);
        chk("no_toggle", pj & pk, 0);
        chk("q_range", (int'(q) < MODULO), 1);
        m_q     = n;
        m_state = ns;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b1;
        load = 1'b0; load_val = '0; oneshot = 1'b0;
        m_q = '0; m_state = M_IDLE;
        #3;
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tc", tc, 0);
        chk("rst_j", j_vec, 0);
        chk("rst_k", k_vec, 0);
        @(negedge clk);
        reset = 1'b1;

        // Start then count up through the wrap
        cycle(1, 0, 1, 0, 0, 0);
        chk("start_q0", q, 0);
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 0, 0);
        chk("at9_q", q, 9);
        chk("at9_tc", tc, 1);
        chk("at9_j", j_vec, 4'b0000);
        chk("at9_k", k_vec, 4'b1001);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        chk("wrap_q1", q, 1);

        // Down count through zero
        cycle(0, 0, 0, 0, 0, 0);
        chk("dn_tc", tc, 1);
        chk("dn_j", j_vec, 4'b1001);
        chk("dn_k", k_vec, 4'b0000);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
        chk("dn_q7", q, 7);

        // Pause, abort, saturated load with start, load in COUNT
        cycle(0, 1, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        chk("abort_q", q, 7);
        cycle(1, 0, 1, 1, 4'd13, 0);
        chk("sat_q", q, 9);
        chk("sat_busy", busy, 0);
        cycle(1, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 1, 4'd5, 0);
        chk("ld5_q", q, 5);
        chk("ld5_busy", busy, 1);

        // One-shot up from 7
        cycle(0, 0, 1, 1, 4'd7, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 1);
        chk("os_done", done, 1);
        chk("os_busy", busy, 0);
        chk("os_q", q, 0);
        cycle(0, 0, 1, 0, 0, 1);
        chk("os_hold", q, 0);
        cycle(1, 0, 1, 0, 0, 1);
        chk("os_clr", done, 0);
        cycle(0, 0, 1, 0, 0, 0);
        chk("os_resume", q, 1);

        // start+stop together, stop in PAUSE
        cycle(1, 1, 1, 0, 0, 0);
        chk("ss_busy", busy, 1);
        chk("ss_q", q, 1);
        cycle(0, 1, 1, 0, 0, 0);
        chk("ps_idle", busy, 0);
        chk("ps_q", q, 1);

        // Asynchronous reset mid-count at q=6
        cycle(1, 0, 1, 0, 0, 0);
        cycle(0, 0, 1, 1, 4'd5, 0);
        cycle(0, 0, 1, 0, 0, 0);
        chk("pre_rst_q", q, 6);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_q", q, 0);
        chk("arst_busy", busy, 0);
        m_q = '0; m_state = M_IDLE;
        @(negedge clk);
        reset = 1'b1;

        // Random stimulus
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 8) == 0, $urandom % 2,
                  ($urandom % 16) == 0, WIDTH'($urandom_range(0, 15)),
                  ($urandom % 4) == 0);
        end

        chk("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
